// File: rtl/alu_pkg.sv
// Opcodes and state types shared by the HI/LO unit (multiplier, divider, control).
package alu_pkg;

   localparam logic [5:0] MULTU = 6'b011001;
   localparam logic [5:0] DIVU  = 6'b011011;
   localparam logic [5:0] OUT   = 6'b111111;

   localparam int DIV_WIDTH = 32;

   // state     | meaning
   // ST_IDLE   | no result computed since reset
   // ST_RUN    | shift-subtract iterations in flight
   // ST_DONE   | completed result held in rem/quot registers
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage : alu_pkg

// File: rtl/divider_step.sv
// One restoring shift-subtract iteration: shifts {rem, quot} left by one,
// then subtracts the divisor from the remainder if it fits.
module divider_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] quot_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic [WIDTH-1:0] quot_o
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] div_ext;
   logic           fits;

   // The incoming remainder is always below the divisor, so its top bit is
   // zero and dropping it in the shift loses nothing; the shifted value can
   // still reach 2^WIDTH and needs the full WIDTH+1 bit compare.
   always_comb begin
      rem_sh  = {rem_i[WIDTH-1:0], quot_i[WIDTH-1]};
      div_ext = {1'b0, divisor_i};
      fits    = (rem_sh >= div_ext);
      rem_o   = fits ? (rem_sh - div_ext) : rem_sh;
      quot_o  = {quot_i[WIDTH-2:0], fits};
   end

endmodule : divider_step

// File: rtl/divider.sv
// Sequential unsigned divider (DIVU) for the HI/LO unit. One quotient bit per
// clock; the {remainder, quotient} result is published on OUT.
//
// state     | meaning
// ST_IDLE   | reset state, result registers zero
// ST_RUN    | iterating, OUT/DIVU ignored
// ST_DONE   | result held until next DIVU or reset
module divider
   import alu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           Signal,
   input  logic [WIDTH-1:0]     dataA,
   input  logic [WIDTH-1:0]     dataB,
   output logic [2*WIDTH-1:0]   dataOut,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   div_state_e          state_q, state_d;
   logic [WIDTH:0]      rem_q, rem_d;
   logic [WIDTH-1:0]    quot_q, quot_d;
   logic [WIDTH-1:0]    divisor_q, divisor_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*WIDTH-1:0]  dout_q, dout_d;

   logic [WIDTH:0]      step_rem;
   logic [WIDTH-1:0]    step_quot;
   logic                is_divu;
   logic                is_out;

   divider_step #(
      .WIDTH     (WIDTH)
   ) u_step (
      .rem_i     (rem_q),
      .quot_i    (quot_q),
      .divisor_i (divisor_q),
      .rem_o     (step_rem),
      .quot_o    (step_quot)
   );

   assign is_divu = (Signal == DIVU);
   assign is_out  = (Signal == OUT);

   // Next-state, datapath register and result publication logic.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      divisor_d = divisor_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (is_out) begin
               dout_d = {rem_q[WIDTH-1:0], quot_q};
            end
            if (is_divu) begin
               if (dataB != '0) begin
                  divisor_d = dataB;
                  quot_d    = dataA;
                  rem_d     = '0;
                  cnt_d     = '0;
                  state_d   = ST_RUN;
               end else begin
                  // Divide by zero: all-ones quotient, dividend as remainder.
                  quot_d  = '1;
                  rem_d   = {1'b0, dataA};
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            rem_d  = step_rem;
            quot_d = step_quot;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         quot_q    <= '0;
         divisor_q <= '0;
         cnt_q     <= '0;
         dout_q    <= '0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         divisor_q <= divisor_d;
         cnt_q     <= cnt_d;
         dout_q    <= dout_d;
      end
   end

   assign dataOut = dout_q;
   assign busy    = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);

endmodule : divider

// File: tb/tb_divider.sv
// Self-checking bench for the sequential DIVU divider.
module tb_divider;
   import alu_pkg::*;

   logic        clk;
   logic        reset;
   logic [5:0]  Signal;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [63:0] dataOut;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   divider #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .Signal  (Signal),
      .dataA   (dataA),
      .dataB   (dataB),
      .dataOut (dataOut),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer division, with the divide-by-zero convention.
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic start_div(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      Signal = DIVU;
      dataA  = a;
      dataB  = b;
      @(negedge clk);
      Signal = 6'h00;
      dataA  = $urandom;
      dataB  = $urandom;
   endtask

   // cyc counts cycles since the DIVU edge; bounded so a stuck DUT still ends.
   task automatic wait_done(input int c0, output int cyc, output bit saw_busy);
      cyc      = c0;
      saw_busy = busy;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         saw_busy |= busy;
      end
   endtask

   task automatic publish();
      @(negedge clk);
      Signal = OUT;
      @(negedge clk);
      Signal = 6'h00;
   endtask

   task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat);
      int cyc;
      bit sb;
      start_div(a, b);
      wait_done(1, cyc, sb);
      check({tag, "_latency"}, 64'(cyc), 64'(lat));
      if (b == 32'd0) check({tag, "_busy_seen"}, {63'd0, sb}, 64'd0);
      publish();
      check({tag, "_result"}, dataOut, exp);
   endtask

   initial begin
      int cyc;
      bit sb;
      logic [31:0] ra, rb;

      vecs[0] = '{32'd100,        32'd7,          64'h00000002_0000000E, 33};
      vecs[1] = '{32'hFFFF_FFFF,  32'h8000_0000,  64'h7FFFFFFF_00000001, 33};
      vecs[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000, 33};
      vecs[3] = '{32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 33};
      vecs[4] = '{32'd0,          32'd5,          64'h00000000_00000000, 33};
      vecs[5] = '{32'd1234,       32'd0,          64'h000004D2_FFFFFFFF, 1};
      vecs[6] = '{32'd5,          32'd9,          64'h00000005_00000000, 33};
      vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000000_00000001, 33};

      reset  = 1'b1;
      Signal = 6'h00;
      dataA  = '0;
      dataB  = '0;
      repeat (3) @(negedge clk);
      check("rst_dataOut", dataOut, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      reset = 1'b0;

      publish();
      check("out_after_reset", dataOut, 64'd0);

      // Directed table, run back to back (each DIVU issued from DONE).
      for (int i = 0; i < 8; i++) begin
         run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      end

      // Non-DIVU/OUT opcode in DONE is ignored.
      @(negedge clk);
      Signal = MULTU;
      @(negedge clk);
      Signal = 6'h00;
      check("multu_ignored_done", {63'd0, done}, 64'd1);
      check("multu_ignored_out", dataOut, vecs[7].exp);

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 255);
            2:       rb = $urandom | 32'h8000_0000;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) ra = ra >> $urandom_range(1, 31);
         run_one($sformatf("rnd%0d", i), ra, rb, model(ra, rb), (rb == 0) ? 1 : 33);
      end

      // Reset during iteration 10 aborts everything on that edge.
      run_one("pre_rst", 32'd100, 32'd7, 64'h00000002_0000000E, 33);
      start_div(32'd100, 32'd7);
      repeat (9) @(negedge clk);
      check("midrun_busy", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_done", {63'd0, done}, 64'd0);
      check("midrst_dataOut", dataOut, 64'd0);
      reset = 1'b0;
      publish();
      check("midrst_out", dataOut, 64'd0);

      // OUT and DIVU during RUN are ignored.
      run_one("first", 32'd100, 32'd7, 64'h00000002_0000000E, 33);
      start_div(32'd50, 32'd3);
      check("run_dataOut_kept", dataOut, 64'h00000002_0000000E);
      Signal = OUT;
      @(negedge clk);
      Signal = DIVU;
      dataA  = 32'd9;
      dataB  = 32'd9;
      @(negedge clk);
      Signal = 6'h00;
      check("run_out_ignored", dataOut, 64'h00000002_0000000E);
      check("run_still_busy", {63'd0, busy}, 64'd1);
      wait_done(3, cyc, sb);
      check("run_latency", 64'(cyc), 64'd33);
      check("run_dataOut_at_done", dataOut, 64'h00000002_0000000E);
      publish();
      check("run_result", dataOut, 64'h00000002_00000010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_divider

// File: doc/divider.md
# divider

Sequential unsigned 32-bit divider executing the DIVU operation, the inverse counterpart of the shift-add multiplier in the datapath's HI/LO unit. It shares the multiplier's opcode-driven interface: the control unit drives `Signal`, operands arrive on `dataA` (dividend) and `dataB` (divisor), and the packed `{remainder, quotient}` result is presented on `dataOut` when OUT is issued. It uses a restoring shift-subtract algorithm, one quotient bit per clock.

## Interface
- `WIDTH`, 32, operand width; `dataOut` is 2*WIDTH.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `Signal`  in  6  opcode: DIVU = 6'b011011 starts, OUT = 6'b111111 publishes result, all others ignored.
- `dataA`  in  32  dividend, sampled on the DIVU edge only.
- `dataB`  in  32  divisor, sampled on the DIVU edge only.
- `dataOut`  out  64  registered result {remainder[31:0], quotient[31:0]} (HI = remainder, LO = quotient).
- `busy`  out  1  high while iterating.
- `done`  out  1  high while a completed result is held.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + DIVU, dataB != 0: latch divisor = dataB, quotient register = dataA, partial remainder (33-bit) = 0, count = 0; -> RUN.
- IDLE/DONE + DIVU, dataB == 0: quotient = 32'hFFFFFFFF, remainder = dataA; -> DONE directly.
- RUN, each edge: {rem, quot} shifted left 1 (quot MSB into rem LSB); if rem (33-bit) >= {1'b0, divisor}, then rem -= divisor and quot[0] = 1, else quot[0] = 0; count++. On the 32nd iteration -> DONE.
- The 33-bit compare is mandatory; the shifted remainder can exceed 2^32-1.
- OUT with state != RUN: dataOut <= {rem[31:0], quot} on that edge. OUT in IDLE after reset publishes 0.
- OUT or DIVU during RUN: ignored; dataOut and the in-flight operation are unaffected.
- dataOut changes only on an accepted OUT or on reset; starting a new DIVU does not clear it.
- Result registers persist in DONE until the next DIVU or reset.
- `busy` = (state == RUN); `done` = (state == DONE).

## Timing
- Reset values: dataOut = 0, busy = 0, done = 0, state IDLE, internal registers 0.
- DIVU sampled at edge 0 -> busy = 1 after edge 0; iterations on edges 1..32; after edge 32 busy = 0, done = 1. Latency is 33 cycles from DIVU to done.
- Divide-by-zero: done = 1 after edge 0, with busy never asserted.
- Earliest useful OUT is the edge after done rises. dataOut is valid one cycle after the OUT edge (registered, no combinational path from Signal).
- Reset mid-RUN: aborts immediately, all outputs return to reset values on that edge, and no partial result is observable.
- Back-to-back operations: DIVU in the DONE cycle restarts with no idle gap.

## Structure
- Shared package (`alu_pkg`): opcode constants MULTU 6'b011001, DIVU 6'b011011, OUT 6'b111111, shared with the multiplier and control unit; divider state enum.
- One sub-module, `divider_step`: combinational single iteration that takes (rem[32:0], quot[31:0], divisor) and returns the next (rem, quot). The top module holds the FSM, counter, and registers.

## Test plan
- 100 / 7: DIVU, wait for done (exactly 33 cycles), then OUT -> dataOut = 64'h00000002_0000000E.
- 0xFFFFFFFF / 0x80000000 -> dataOut = 64'h7FFFFFFF_00000001. Also 0x80000000 / 0xFFFFFFFF -> 64'h80000000_00000000. These exercise the 33-bit compare.
- 0xFFFFFFFF / 1 -> 64'h00000000_FFFFFFFF. 0 / 5 -> all zeros.
- 1234 / 0 -> done one cycle after DIVU, busy never high; OUT -> 64'h000004D2_FFFFFFFF.
- DIVU 100 / 7, then reset at iteration 10 -> busy = 0, done = 0, dataOut = 0 on that edge; a subsequent OUT gives 0.
- First op 100 / 7 completed and published. Start 50 / 3, and during RUN issue OUT and DIVU 9 / 9 -> dataOut stays 64'h00000002_0000000E, the final result is q = 16, r = 2, and the second DIVU has no effect.
